// File: rtl/hdr_cmd_arbiter.sv
// hdr_cmd_arbiter: shares one S2MM datamover command/status pair between NREQ requesters; status is routed back in command order.
// Latency: grant and capture in the request cycle, m_cmd_tvalid the next cycle (peak 1 cmd / 2 cycles); status routing is combinational.
// Backpressure: m_cmd_tready stalls ISSUE; head lane's m_sts_tready drives s_sts_tready; grants stop at MAX_OUTSTANDING in flight.
// Optional watchdog (timeout_o) is built only when HDR_CMD_ARBITER_WATCHDOG_EN is defined.

// hdr_cmd_fifo: small generic synchronous FIFO holding requester indices in command order.
// Latency: a push is visible on rd_dat/rd_vld the cycle after it is written.
// Backpressure: writes are ignored when full, reads when empty; the arbiter never pushes when full.
module hdr_cmd_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         rd_vld
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr];

    // Storage: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module hdr_cmd_arbiter #(
    parameter int NREQ            = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 65536
) (
    input  logic                               memclk,
    input  logic                               memrst,
    input  logic [72*NREQ-1:0]                 s_cmd_tdata,
    input  logic [NREQ-1:0]                    s_cmd_tvalid,
    output logic [NREQ-1:0]                    s_cmd_tready,
    output logic [71:0]                        m_cmd_tdata,
    output logic                               m_cmd_tvalid,
    input  logic                               m_cmd_tready,
    input  logic [7:0]                         s_sts_tdata,
    input  logic                               s_sts_tvalid,
    output logic                               s_sts_tready,
    output logic [8*NREQ-1:0]                  m_sts_tdata,
    output logic [NREQ-1:0]                    m_sts_tvalid,
    input  logic [NREQ-1:0]                    m_sts_tready,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               stray_sts_o,
    output logic                               timeout_o
);
    localparam int                IDX_W    = $clog2(NREQ);
    localparam int                CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0]  LAST_REQ = IDX_W'(NREQ - 1);

    // Elaboration-time parameter range checks.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("hdr_cmd_arbiter: NREQ must be 2..8");
    end
    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 32 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max
        $error("hdr_cmd_arbiter: MAX_OUTSTANDING must be a power of 2 in 2..32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("hdr_cmd_arbiter: TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] head_idx;
    logic [71:0]      win_dat;
    logic             win_vld;
    logic             grant;
    logic             cmd_hs;
    logic             head_vld;
    logic             sts_hs;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NREQ);
            if (!win_vld && s_cmd_tvalid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Select the winning requester's command word.
    always_comb begin
        win_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDX_W'(i)) win_dat = s_cmd_tdata[72*i +: 72];
        end
    end

    assign grant  = !memrst && (state == IDLE) && win_vld && (outstanding_o < MAX_CNT);
    assign cmd_hs = m_cmd_tvalid && m_cmd_tready;

    // Ready only to the winner, only in the granting IDLE cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            s_cmd_tready[i] = grant && (win_idx == IDX_W'(i));
        end
    end

    // Command FSM: capture in IDLE, hold valid/data in ISSUE until accepted.
    always_ff @(posedge memclk) begin
        if (memrst) begin
            state        <= IDLE;
            m_cmd_tvalid <= 1'b0;
            m_cmd_tdata  <= '0;
            last_grant   <= LAST_REQ;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        m_cmd_tdata  <= win_dat;
                        m_cmd_tvalid <= 1'b1;
                        last_grant   <= win_idx;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_cmd_tready) begin
                        m_cmd_tvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Order FIFO: last_grant still names the issuing requester during ISSUE.
    hdr_cmd_fifo #(
        .W     (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk    (memclk),
        .rst    (memrst),
        .wr_vld (cmd_hs),
        .wr_dat (last_grant),
        .rd_rdy (sts_hs),
        .rd_dat (head_idx),
        .rd_vld (head_vld)
    );

    assign sts_hs       = !memrst && head_vld && s_sts_tvalid && m_sts_tready[head_idx];
    assign s_sts_tready = !memrst && (head_vld ? m_sts_tready[head_idx] : 1'b1);
    assign m_sts_tdata  = {NREQ{s_sts_tdata}};

    // Status valid goes only to the lane at the head of the order FIFO.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            m_sts_tvalid[i] = !memrst && head_vld && s_sts_tvalid && (head_idx == IDX_W'(i));
        end
    end

    // In-flight count and sticky stray-status flag.
    always_ff @(posedge memclk) begin
        if (memrst) begin
            outstanding_o <= '0;
            stray_sts_o   <= 1'b0;
        end else begin
            if (cmd_hs && !sts_hs) begin
                outstanding_o <= outstanding_o + CNT_W'(1);
            end else if (sts_hs && !cmd_hs) begin
                outstanding_o <= outstanding_o - CNT_W'(1);
            end
            if (!head_vld && s_sts_tvalid) stray_sts_o <= 1'b1;
        end
    end

`ifdef HDR_CMD_ARBITER_WATCHDOG_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0] wd_cnt;

    // Watchdog: count cycles with commands in flight and no status progress.
    always_ff @(posedge memclk) begin
        if (memrst) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else if (sts_hs || outstanding_o == '0) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + 32'd1;
            if (wd_cnt + 32'd1 == WD_LIMIT) timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_hdr_cmd_arbiter.sv
// tb_hdr_cmd_arbiter: directed table-driven checks of hdr_cmd_arbiter with NREQ=2, MAX_OUTSTANDING=8.
// Inputs change 1ns after the rising edge, outputs are compared 1ns later.
// Hand sequences cover the full condition, reset with commands in flight and the optional watchdog.
module tb_hdr_cmd_arbiter;
    localparam int NREQ = 2;
    localparam int MAXO = 8;
`ifdef HDR_CMD_ARBITER_WATCHDOG_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65536;
`endif

    logic               memclk = 1'b0;
    logic               memrst = 1'b1;
    logic [72*NREQ-1:0] s_cmd_tdata;
    logic [NREQ-1:0]    s_cmd_tvalid = '0;
    logic [NREQ-1:0]    s_cmd_tready;
    logic [71:0]        m_cmd_tdata;
    logic               m_cmd_tvalid;
    logic               m_cmd_tready = 1'b0;
    logic [7:0]         s_sts_tdata = '0;
    logic               s_sts_tvalid = 1'b0;
    logic               s_sts_tready;
    logic [8*NREQ-1:0]  m_sts_tdata;
    logic [NREQ-1:0]    m_sts_tvalid;
    logic [NREQ-1:0]    m_sts_tready = '1;
    logic [3:0]         outstanding_o;
    logic               stray_sts_o;
    logic               timeout_o;

    logic [71:0] req_dat [NREQ];

    always #5 memclk = ~memclk;

    hdr_cmd_arbiter #(
        .NREQ            (NREQ),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .memclk        (memclk),
        .memrst        (memrst),
        .s_cmd_tdata   (s_cmd_tdata),
        .s_cmd_tvalid  (s_cmd_tvalid),
        .s_cmd_tready  (s_cmd_tready),
        .m_cmd_tdata   (m_cmd_tdata),
        .m_cmd_tvalid  (m_cmd_tvalid),
        .m_cmd_tready  (m_cmd_tready),
        .s_sts_tdata   (s_sts_tdata),
        .s_sts_tvalid  (s_sts_tvalid),
        .s_sts_tready  (s_sts_tready),
        .m_sts_tdata   (m_sts_tdata),
        .m_sts_tvalid  (m_sts_tvalid),
        .m_sts_tready  (m_sts_tready),
        .outstanding_o (outstanding_o),
        .stray_sts_o   (stray_sts_o),
        .timeout_o     (timeout_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge memclk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] cvld;
        logic       mrdy;
        logic       svld;
        logic [7:0] sts;
        logic [1:0] srdy;
        logic [1:0] e_crdy;
        logic       e_mcv;
        int         e_src;
        logic       e_srdy;
        logic [1:0] e_msv;
        int         e_out;
        logic       e_stray;
    } vec_t;

    vec_t tbl[34];

    function automatic vec_t mk(logic rst, logic [1:0] cvld, logic mrdy, logic svld, logic [7:0] sts,
                                logic [1:0] srdy, logic [1:0] e_crdy, logic e_mcv, int e_src,
                                logic e_srdy, logic [1:0] e_msv, int e_out, logic e_stray);
        vec_t v;
        v.rst = rst; v.cvld = cvld; v.mrdy = mrdy; v.svld = svld; v.sts = sts; v.srdy = srdy;
        v.e_crdy = e_crdy; v.e_mcv = e_mcv; v.e_src = e_src; v.e_srdy = e_srdy;
        v.e_msv = e_msv; v.e_out = e_out; v.e_stray = e_stray;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        req_dat[0]  = 72'h00_12340000_C0000100;
        req_dat[1]  = 72'h01_56780000_C0000200;
        s_cmd_tdata = {req_dat[1], req_dat[0]};

        //            rst cvld  mrdy svld sts    srdy  | crdy mcv src srdy msv  out stray
        // single request and its status
        tbl[0]  = mk(0, 2'b01, 1, 0, 8'h00, 2'b11, 2'b01, 0, 0, 1, 2'b00, 0, 0);
        tbl[1]  = mk(0, 2'b00, 1, 0, 8'h00, 2'b11, 2'b00, 1, 0, 1, 2'b00, 0, 0);
        tbl[2]  = mk(0, 2'b00, 1, 1, 8'h83, 2'b11, 2'b00, 0, 0, 1, 2'b01, 1, 0);
        tbl[3]  = mk(1, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        // round robin 0,1,0,1 then in-order status routing
        tbl[4]  = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b01, 0, 0, 1, 2'b00, 0, 0);
        tbl[5]  = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b00, 1, 0, 1, 2'b00, 0, 0);
        tbl[6]  = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b10, 0, 0, 1, 2'b00, 1, 0);
        tbl[7]  = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b00, 1, 1, 1, 2'b00, 1, 0);
        tbl[8]  = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b01, 0, 0, 1, 2'b00, 2, 0);
        tbl[9]  = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b00, 1, 0, 1, 2'b00, 2, 0);
        tbl[10] = mk(0, 2'b11, 1, 0, 8'h00, 2'b11, 2'b10, 0, 0, 1, 2'b00, 3, 0);
        tbl[11] = mk(0, 2'b00, 1, 0, 8'h00, 2'b11, 2'b00, 1, 1, 1, 2'b00, 3, 0);
        tbl[12] = mk(0, 2'b00, 1, 1, 8'h80, 2'b11, 2'b00, 0, 0, 1, 2'b01, 4, 0);
        tbl[13] = mk(0, 2'b00, 1, 1, 8'h81, 2'b11, 2'b00, 0, 0, 1, 2'b10, 3, 0);
        tbl[14] = mk(0, 2'b00, 1, 1, 8'h82, 2'b11, 2'b00, 0, 0, 1, 2'b01, 2, 0);
        tbl[15] = mk(0, 2'b00, 1, 1, 8'h83, 2'b11, 2'b00, 0, 0, 1, 2'b10, 1, 0);
        tbl[16] = mk(0, 2'b00, 1, 0, 8'h00, 2'b11, 2'b00, 0, 0, 1, 2'b00, 0, 0);
        // command backpressure for 5 cycles, then status backpressure on lane 0
        tbl[17] = mk(0, 2'b01, 0, 0, 8'h00, 2'b11, 2'b01, 0, 0, 1, 2'b00, 0, 0);
        for (int r = 18; r <= 22; r++)
            tbl[r] = mk(0, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 1, 0, 1, 2'b00, 0, 0);
        tbl[23] = mk(0, 2'b00, 1, 0, 8'h00, 2'b11, 2'b00, 1, 0, 1, 2'b00, 0, 0);
        tbl[24] = mk(0, 2'b00, 1, 1, 8'h85, 2'b00, 2'b00, 0, 0, 0, 2'b01, 1, 0);
        tbl[25] = mk(0, 2'b00, 1, 1, 8'h85, 2'b00, 2'b00, 0, 0, 0, 2'b01, 1, 0);
        tbl[26] = mk(0, 2'b00, 1, 1, 8'h85, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0);
        tbl[27] = mk(0, 2'b00, 1, 0, 8'h00, 2'b11, 2'b00, 0, 0, 1, 2'b00, 0, 0);
        // stray status, then reset while a command is held in ISSUE
        tbl[28] = mk(0, 2'b00, 1, 1, 8'h44, 2'b11, 2'b00, 0, 0, 1, 2'b00, 0, 0);
        tbl[29] = mk(0, 2'b00, 1, 0, 8'h00, 2'b11, 2'b00, 0, 0, 1, 2'b00, 0, 1);
        tbl[30] = mk(0, 2'b10, 0, 0, 8'h00, 2'b11, 2'b10, 0, 0, 1, 2'b00, 0, 1);
        tbl[31] = mk(0, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 1, 1, 1, 2'b00, 0, 1);
        tbl[32] = mk(1, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 1, 1, 0, 2'b00, 0, 1);
        tbl[33] = mk(0, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 0, 0, 1, 2'b00, 0, 0);

        // reset state
        memrst = 1'b1;
        repeat (3) tick();
        #1;
        chk("reset s_cmd_tready", s_cmd_tready, 0);
        chk("reset m_cmd_tvalid", m_cmd_tvalid, 0);
        chk("reset s_sts_tready", s_sts_tready, 0);
        chk("reset m_sts_tvalid", m_sts_tvalid, 0);
        chk("reset outstanding", outstanding_o, 0);
        chk("reset stray", stray_sts_o, 0);
        chk("reset timeout", timeout_o, 0);
        memrst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            memrst       = tbl[i].rst;
            s_cmd_tvalid = tbl[i].cvld;
            m_cmd_tready = tbl[i].mrdy;
            s_sts_tvalid = tbl[i].svld;
            s_sts_tdata  = tbl[i].sts;
            m_sts_tready = tbl[i].srdy;
            #1;
            chk($sformatf("row%0d s_cmd_tready", i), s_cmd_tready, tbl[i].e_crdy);
            chk($sformatf("row%0d m_cmd_tvalid", i), m_cmd_tvalid, tbl[i].e_mcv);
            if (tbl[i].e_mcv)
                chk($sformatf("row%0d m_cmd_tdata", i), m_cmd_tdata, req_dat[tbl[i].e_src]);
            chk($sformatf("row%0d s_sts_tready", i), s_sts_tready, tbl[i].e_srdy);
            chk($sformatf("row%0d m_sts_tvalid", i), m_sts_tvalid, tbl[i].e_msv);
            if (tbl[i].e_msv != 2'b00)
                chk($sformatf("row%0d m_sts_tdata", i), m_sts_tdata, {tbl[i].sts, tbl[i].sts});
            chk($sformatf("row%0d outstanding", i), outstanding_o, tbl[i].e_out);
            chk($sformatf("row%0d stray", i), stray_sts_o, tbl[i].e_stray);
            tick();
        end

        // Fill to MAX_OUTSTANDING from requester 0 with no status returning.
        memrst       = 1'b0;
        s_cmd_tvalid = 2'b01;
        m_cmd_tready = 1'b1;
        s_sts_tvalid = 1'b0;
        m_sts_tready = 2'b11;
        for (int k = 0; k < MAXO; k++) begin
            #1;
            chk($sformatf("fill%0d grant", k), s_cmd_tready, 2'b01);
            chk($sformatf("fill%0d outstanding", k), outstanding_o, k);
            tick();
            #1;
            chk($sformatf("fill%0d m_cmd_tvalid", k), m_cmd_tvalid, 1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("full%0d no grant", k), s_cmd_tready, 2'b00);
            chk($sformatf("full%0d outstanding", k), outstanding_o, MAXO);
            tick();
        end
        s_sts_tvalid = 1'b1;
        s_sts_tdata  = 8'h86;
        #1;
        chk("full sts m_sts_tvalid", m_sts_tvalid, 2'b01);
        chk("full sts s_sts_tready", s_sts_tready, 1);
        chk("full sts no grant", s_cmd_tready, 2'b00);
        tick();
        s_sts_tvalid = 1'b0;
        #1;
        chk("after pop outstanding", outstanding_o, MAXO - 1);
        chk("after pop grant", s_cmd_tready, 2'b01);
        tick();
        #1;
        chk("refill m_cmd_tvalid", m_cmd_tvalid, 1);
        tick();
        #1;
        chk("refill outstanding", outstanding_o, MAXO);
        chk("refill no grant", s_cmd_tready, 2'b00);

        // Reset with commands in flight: their later status is stray.
        s_cmd_tvalid = 2'b00;
        memrst       = 1'b1;
        tick();
        tick();
        memrst = 1'b0;
        #1;
        chk("post-reset outstanding", outstanding_o, 0);
        chk("post-reset stray", stray_sts_o, 0);
        s_sts_tvalid = 1'b1;
        s_sts_tdata  = 8'h87;
        #1;
        chk("late sts s_sts_tready", s_sts_tready, 1);
        chk("late sts m_sts_tvalid", m_sts_tvalid, 2'b00);
        tick();
        s_sts_tvalid = 1'b0;
        #1;
        chk("late sts stray", stray_sts_o, 1);
        chk("late sts outstanding", outstanding_o, 0);

`ifdef HDR_CMD_ARBITER_WATCHDOG_EN
        // Watchdog: one command, no status, timeout after TIMEOUT_CYCLES.
        memrst = 1'b1;
        tick();
        memrst       = 1'b0;
        s_cmd_tvalid = 2'b01;
        m_cmd_tready = 1'b1;
        tick();
        s_cmd_tvalid = 2'b00;
        tick();
        #1;
        chk("wd outstanding", outstanding_o, 1);
        repeat (TMO - 1) tick();
        chk("wd before limit", timeout_o, 0);
        tick();
        chk("wd at limit", timeout_o, 1);
        s_sts_tvalid = 1'b1;
        s_sts_tdata  = 8'h88;
        tick();
        s_sts_tvalid = 1'b0;
        #1;
        chk("wd sticky", timeout_o, 1);
        chk("wd outstanding cleared", outstanding_o, 0);
`else
        chk("timeout tied low", timeout_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
